// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - serial double-dabble binary to BCD converter with saturation
//
// Purpose:
//   Converts an unsigned DIN_W-bit operand into DIGITS packed BCD digits.
//   It performs one shift-add-3 iteration per clock, MSB first. A conversion
//   takes DIN_W cycles from the edge that accepts start to the edge that raises
//   done. Operands larger than 10^DIGITS-1 saturate to all nines and set ovf.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous active-high reset
//   start  in   1          conversion request, level-sampled while idle
//   din    in   DIN_W      unsigned operand, captured with an accepted start
//   busy   out  1          conversion in progress
//   done   out  1          one-cycle pulse when bcd/ovf/ndig are updated
//   bcd    out  4*DIGITS   last result, digit 0 (units) in bits [3:0]
//   ovf    out  1          last result was saturated
//   ndig   out  4          significant digit count of last result (1..DIGITS)

module bin2bcd_serial #(
  parameter int DIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIN_W-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [3:0]            ndig
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIN_W + 1);

  // Largest representable value, 10^DIGITS-1. This is held in 64 bits because
  // 10^10-1 does not fit in 32.
  function automatic logic [63:0] bcd_limit(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LIMIT = bcd_limit(DIGITS);

  // Index of the highest nonzero digit plus one. A zero value reports 1.
  function automatic logic [3:0] count_digits(input logic [BCD_W-1:0] v);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) begin
        n = 4'(i + 1);
      end
    end
    return n;
  endfunction

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state, state_nxt;
  logic [DIN_W-1:0]   sh_q;
  logic [BCD_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;

  logic               accept;
  logic               last_iter;
  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_nxt;
  logic [BCD_W-1:0]   result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt_q == CNT_W'(DIN_W - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and controls
  always_comb begin
    busy      = (state == CONV);
    accept    = (state == IDLE) && start;
    last_iter = (state == CONV) && (cnt_q == CNT_W'(DIN_W - 1));
  end

  // One double-dabble step. Each digit of 5 or more is corrected by +3, then
  // the whole register shifts left and takes in the next operand MSB.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_nxt = (acc_adj << 1) | BCD_W'(sh_q[DIN_W-1]);
    // If the operand was out of range, the accumulator has overflowed and its
    // contents are meaningless. Saturation replaces it outright.
    result  = sat_q ? {DIGITS{4'h9}} : acc_nxt;
  end

  // Datapath and result registers. bcd/ovf/ndig change only on completion, so
  // intermediate shift contents are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      ovf   <= 1'b0;
      ndig  <= 4'd1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sh_q  <= din;
        acc_q <= '0;
        cnt_q <= '0;
        sat_q <= 64'(din) > LIMIT;
      end else if (state == CONV) begin
        sh_q  <= sh_q << 1;
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + 1'b1;
        if (last_iter) begin
          bcd  <= result;
          ovf  <= sat_q;
          ndig <= count_digits(result);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb/tb_bin2bcd_serial.sv - directed-vector bench for bin2bcd_serial

module tb_bin2bcd_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic [7:0]  din_a = '0;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [3:0]  ndig_a;

  logic        start_b = 1'b0;
  logic [6:0]  din_b = '0;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [3:0]  ndig_b;

  int n_vec = 0;
  int n_err = 0;
  int sel = 0;

  logic        obs_busy, obs_done, obs_ovf;
  logic [11:0] obs_bcd;
  logic [3:0]  obs_ndig;

  bin2bcd_serial #(.DIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .ndig(ndig_a)
  );

  bin2bcd_serial #(.DIN_W(7), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .ndig(ndig_b)
  );

  assign obs_busy = (sel == 0) ? busy_a : busy_b;
  assign obs_done = (sel == 0) ? done_a : done_b;
  assign obs_ovf  = (sel == 0) ? ovf_a  : ovf_b;
  assign obs_bcd  = (sel == 0) ? bcd_a  : {4'h0, bcd_b};
  assign obs_ndig = (sel == 0) ? ndig_a : ndig_b;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one conversion on the selected instance and check it end to end.
  task automatic run(input int s, input logic [7:0] v, input logic [11:0] eb,
                     input logic eo, input logic [3:0] en, input string tag);
    int          lat;
    logic        busy_ok, hold_ok;
    logic [11:0] prev;
    sel = s;
    #0;
    prev    = obs_bcd;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    if (s == 0) begin start_a = 1'b1; din_a = v; end
    else        begin start_b = 1'b1; din_b = v[6:0]; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    din_a   = ~v;
    din_b   = ~v[6:0];
    lat = 0;
    while (!obs_done && lat < 40) begin
      if (!obs_busy) busy_ok = 1'b0;
      if (obs_bcd !== prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, (s == 0) ? 8 : 7);
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_bcd_hold"}, hold_ok, 1);
    check({tag, "_bcd"}, obs_bcd, eb);
    check({tag, "_ovf"}, obs_ovf, eo);
    check({tag, "_ndig"}, obs_ndig, en);
    check({tag, "_busy_at_done"}, obs_busy, 0);
    tick();
    check({tag, "_done_pulse"}, obs_done, 0);
  endtask

  initial begin
    int          ndone;
    int          when [$];
    logic [11:0] got;

    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_bcd", bcd_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_ndig", ndig_a, 1);
    check("rst_ndig_b", ndig_b, 1);

    run(0, 8'd255, 12'h255, 1'b0, 4'd3, "a255");
    run(0, 8'd0,   12'h000, 1'b0, 4'd1, "a0");
    run(0, 8'd99,  12'h099, 1'b0, 4'd2, "a99");
    run(0, 8'd100, 12'h100, 1'b0, 4'd3, "a100");
    run(0, 8'd9,   12'h009, 1'b0, 4'd1, "a9");
    run(0, 8'd10,  12'h010, 1'b0, 4'd2, "a10");
    run(0, 8'd128, 12'h128, 1'b0, 4'd3, "a128");

    run(1, 8'd127, 12'h099, 1'b1, 4'd2, "b127");
    run(1, 8'd99,  12'h099, 1'b0, 4'd2, "b99");
    run(1, 8'd100, 12'h099, 1'b1, 4'd2, "b100");
    run(1, 8'd5,   12'h005, 1'b0, 4'd1, "b5");
    run(1, 8'd0,   12'h000, 1'b0, 4'd1, "b0");

    // A start request made while busy is dropped.
    sel = 0;
    start_a = 1'b1; din_a = 8'd37;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    start_a = 1'b1; din_a = 8'd200;
    tick();
    start_a = 1'b0;
    ndone = 0;
    got = '0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done_a) begin ndone++; got = bcd_a; end
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_bcd", got, 12'h037);

    // Holding start high retriggers the converter each time it returns to IDLE.
    start_a = 1'b1; din_a = 8'd5;
    for (int c = 0; c < 45; c++) begin
      if (c == 30) start_a = 1'b0;
      tick();
      if (done_a) begin
        when.push_back(c);
        check("held_bcd", bcd_a, 12'h005);
      end
    end
    check("held_ndone", when.size(), 4);
    if (when.size() > 0) check("held_first", when[0], 8);
    for (int i = 1; i < when.size(); i++) check("held_spacing", when[i] - when[i-1], 9);

    // Reset during a conversion aborts it.
    start_a = 1'b1; din_a = 8'd200;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_bcd", bcd_a, 0);
    check("abort_ovf", ovf_a, 0);
    check("abort_ndig", ndig_a, 1);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_a) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run(0, 8'd12, 12'h012, 1'b0, 4'd2, "a12");

    // When rst and start arrive on the same edge, rst wins.
    rst = 1'b1; start_a = 1'b1; din_a = 8'd50;
    tick();
    rst = 1'b0; start_a = 1'b0;
    check("rst_prio_busy", busy_a, 0);
    tick();
    check("rst_prio_busy2", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_serial.md
BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

Interface
REQ-001 SHALL have parameter DIN_W, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digit count, legal range 1..10.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: conversion request, sampled on the rising edge of clk.
REQ-006 SHALL have port din, input, DIN_W: unsigned binary operand, sampled together with an accepted start.
REQ-007 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when a result is updated.
REQ-009 SHALL have port bcd, output, 4*DIGITS: packed result; digit 0 (units) in bits [3:0].
REQ-010 SHALL have port ovf, output, 1: last result saturated.
REQ-011 SHALL have port ndig, output, 4: count of significant digits in the last result (1..DIGITS).

Function
REQ-012 SHALL implement two states, IDLE and CONV; the reset state is IDLE.
REQ-013 In IDLE with start=1 at edge k, SHALL latch din, enter CONV, and drive busy=1 from edge k.
REQ-014 In CONV, SHALL perform one shift-add-3 (double-dabble) iteration per edge, MSB first: any BCD digit >=5 gets +3 before the left shift.
REQ-015 SHALL complete after exactly DIN_W iterations, at edge k+DIN_W; at that edge it SHALL update bcd, ovf and ndig, set done=1 for one cycle, set busy=0, and return to IDLE.
REQ-016 Latency from the start-accept edge to the done-high edge SHALL be DIN_W cycles, independent of operand value.
REQ-017 start while busy=1 SHALL be ignored, with no queueing and no effect on the running conversion.
REQ-018 start in the cycle where done=1 SHALL be accepted, because the state is IDLE; back-to-back throughput is one conversion per DIN_W+1 cycles.
REQ-019 start held high SHALL retrigger each time IDLE is reached; it is level-sampled, not edge-detected.
REQ-020 If the latched operand > 10^DIGITS-1, the result SHALL be all digits 9 and ovf=1; otherwise ovf=0. The comparison is made at latch time.
REQ-021 ndig SHALL equal the index of the highest nonzero digit plus 1; for a zero result it SHALL be 1; for a saturated result it SHALL be DIGITS.
REQ-022 bcd, ovf and ndig SHALL hold their last values between completions and SHALL NOT show intermediate shift-register contents.
REQ-023 Internal BCD register width SHALL be 4*DIGITS bits, plus a DIN_W-bit shift register and a counter of ceil(log2(DIN_W+1)) bits; nothing shall truncate before saturation is applied.
REQ-024 din changes after the accept edge SHALL NOT affect the result.

Reset
REQ-025 rst=1 at a rising edge SHALL force the state to IDLE and set busy=0, done=0, bcd=0, ovf=0, ndig=1.
REQ-026 rst asserted mid-conversion SHALL abort the conversion with no done pulse; the partial result SHALL be discarded.
REQ-027 rst SHALL take priority over start at the same edge.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Verification (DIN_W=8, DIGITS=3 unless stated)
REQ-029 start=1, din=255 at edge k -> busy=1 over edges k..k+7; done=1 after edge k+8; bcd=0x255, ovf=0, ndig=3.
REQ-030 din=0 -> bcd=0x000, ndig=1; din=99 -> bcd=0x099, ndig=2; din=100 -> bcd=0x100, ndig=3.
REQ-031 DIN_W=7, DIGITS=2: din=127 -> bcd=0x99, ovf=1, ndig=2; din=99 -> bcd=0x99, ovf=0.
REQ-032 start=1, din=37, then start=1, din=200 at edge k+3 -> single done with bcd=0x037; second request ignored.
REQ-033 start held high for 30 cycles, din=5 -> done pulses at 9-cycle spacing; each result is bcd=0x005.
REQ-034 rst=1 at edge k+4 of a din=200 conversion -> no done pulse; outputs at reset values; next start, din=12 -> bcd=0x012 after 8 cycles.
